// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the CPU sequencer and the datapath.
// Holds the FSM state encoding, the instruction-register field positions,
// the opcode constants and a helper that maps an opcode onto the class of
// work the sequencer has to schedule for it.
package cpu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_DELAY  = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // Instruction register field positions
    localparam int OPER_HI      = 31;
    localparam int OPER_LO      = 27;
    localparam int RDST_HI      = 26;
    localparam int RDST_LO      = 22;
    localparam int RSRC1_HI     = 21;
    localparam int RSRC1_LO     = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_HI     = 15;
    localparam int RSRC2_LO     = 11;
    localparam int ISRC_HI      = 15;
    localparam int ISRC_LO      = 0;

    // Opcodes 00000..01011 are all ALU operations
    localparam logic [4:0] OP_ALU_LAST = 5'b01011;
    localparam logic [4:0] OP_STOREREG = 5'b01101;
    localparam logic [4:0] OP_STOREDIN = 5'b01110;
    localparam logic [4:0] OP_SENDDOUT = 5'b01111;
    localparam logic [4:0] OP_SENDREG  = 5'b10000;
    localparam logic [4:0] OP_JUMP     = 5'b10010;
    localparam logic [4:0] OP_JZ       = 5'b10100;
    localparam logic [4:0] OP_HALT     = 5'b10110;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_MEM_WR = 3'd2,
        CLS_MEM_RD = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_JZ     = 3'd5,
        CLS_HALT   = 3'd6
    } op_class_e;

    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e cls;
        cls = CLS_NOP;
        if (op <= OP_ALU_LAST) begin
            cls = CLS_ALU;
        end else begin
            case (op)
                OP_STOREREG, OP_STOREDIN: cls = CLS_MEM_WR;
                OP_SENDDOUT, OP_SENDREG:  cls = CLS_MEM_RD;
                OP_JUMP:                  cls = CLS_JUMP;
                OP_JZ:                    cls = CLS_JZ;
                OP_HALT:                  cls = CLS_HALT;
                default:                  cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer FSM for a small multi-cycle CPU.
// Fetches an instruction at the PC, classifies it, issues the matching
// execute / memory / write-back strobes, then idles DLY_CYC cycles before
// the next fetch. All outputs are registered.
//
// Ports:
//   clk        system clock (rising edge)
//   sys_rest   asynchronous active-low reset
//   ir_in      instruction word at imem_addr
//   zero_flag  ALU zero flag, used by jz in DECODE
//   mem_ack    data-memory completion strobe (only honoured in MEM)
//   resume     pulse that releases HALT
//   imem_addr  program counter
//   ir_q       latched instruction register
//   ir_load    high during the FETCH cycle (ir_q loads at its end)
//   exec_en    ALU execute strobe (EXEC)
//   gpr_we     register-file write strobe (EXEC, WB)
//   mem_req    data-memory request (MEM), mem_we gives direction
//   halted     high while in HALT
//   state_o    current state encoding
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DLY_CYC = 3
) (
    input  logic              clk,
    input  logic              sys_rest,
    input  logic [31:0]       ir_in,
    input  logic              zero_flag,
    input  logic              mem_ack,
    input  logic              resume,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       ir_q,
    output logic              ir_load,
    output logic              exec_en,
    output logic              gpr_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic              halted,
    output logic [2:0]        state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_d;
    logic [3:0]        cnt_q, cnt_d;
    // Set when a jump/taken jz already loaded the PC, so DELAY exit must not increment it
    logic              jmp_q, jmp_d;
    logic              ir_load_q, ir_load_d;
    logic              exec_en_q, exec_en_d;
    logic              gpr_we_q, gpr_we_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              halted_q, halted_d;
    logic [31:0]       ir_r_q;
    op_class_e         op_cls;

    assign op_cls = classify(ir_r_q[OPER_HI:OPER_LO]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_r_q;
        cnt_d   = cnt_q;
        jmp_d   = jmp_q;

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                ir_d    = ir_in;
                jmp_d   = 1'b0;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (op_cls)
                    CLS_ALU:                state_d = ST_EXEC;
                    CLS_MEM_WR, CLS_MEM_RD: state_d = ST_MEM;
                    CLS_HALT:               state_d = ST_HALT;
                    CLS_JUMP: begin
                        pc_d    = ir_r_q[ADDR_W-1:0];
                        jmp_d   = 1'b1;
                        state_d = ST_DELAY;
                    end
                    CLS_JZ: begin
                        if (zero_flag) begin
                            pc_d  = ir_r_q[ADDR_W-1:0];
                            jmp_d = 1'b1;
                        end
                        state_d = ST_DELAY;
                    end
                    default:                state_d = ST_DELAY;
                endcase
            end
            ST_EXEC:  state_d = ST_DELAY;
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = (ir_r_q[OPER_HI:OPER_LO] == OP_SENDREG) ? ST_WB : ST_DELAY;
                end
            end
            ST_WB:    state_d = ST_DELAY;
            ST_DELAY: begin
                // Counter holds the remaining DELAY cycles including this one
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_FETCH;
                    if (!jmp_q) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_DELAY;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (state_d == ST_DELAY && state_q != ST_DELAY) begin
            cnt_d = 4'(DLY_CYC);
        end

        // Strobes follow the state being entered so they are high for exactly that state
        ir_load_d = (state_d == ST_FETCH);
        exec_en_d = (state_d == ST_EXEC);
        gpr_we_d  = (state_d == ST_EXEC) || (state_d == ST_WB);
        mem_req_d = (state_d == ST_MEM);
        mem_we_d  = (state_d == ST_MEM) && (op_cls == CLS_MEM_WR);
        halted_d  = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge sys_rest) begin
        if (!sys_rest) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_r_q    <= '0;
            cnt_q     <= '0;
            jmp_q     <= 1'b0;
            ir_load_q <= 1'b0;
            exec_en_q <= 1'b0;
            gpr_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_r_q    <= ir_d;
            cnt_q     <= cnt_d;
            jmp_q     <= jmp_d;
            ir_load_q <= ir_load_d;
            exec_en_q <= exec_en_d;
            gpr_we_q  <= gpr_we_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            halted_q  <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign ir_q      = ir_r_q;
    assign ir_load   = ir_load_q;
    assign exec_en   = exec_en_q;
    assign gpr_we    = gpr_we_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign halted    = halted_q;
    assign state_o   = state_q;

endmodule
